// File: rtl/sat_pack_queue.sv
// sat_pack_queue: clamps signed IN_W-bit samples to OUT_W bits, packs DEPTH of
// them into one vector and hands the vector to a valid/ready consumer. The
// fill register and the output register form a double buffer, so input keeps
// flowing while a finished vector waits. Supports a zero-padded partial flush
// and per-vector saturation reporting.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   sample handshake; in_data is a signed IN_W-bit sample
//   flush               single-cycle request to emit the partial vector
//   out_valid/out_ready vector handshake
//   out_vector          element k = bits [k*OUT_W +: OUT_W]; element DEPTH-1 oldest
//   out_count           number of real samples in out_vector (1..DEPTH)
//   sat_any             at least one real element of out_vector was clamped
//   level               samples currently held in the fill register
module sat_pack_queue #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned SIGNED_OUT = 0,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DEPTH*OUT_W-1:0]   out_vector,
    output logic [CNT_W-1:0]         out_count,
    output logic                     sat_any,
    output logic [CNT_W-1:0]         level
);

    localparam int unsigned VEC_W = DEPTH * OUT_W;
    localparam int unsigned SH_W  = $clog2(VEC_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    // Fill register: element 0 newest, element level-1 oldest.
    logic [DEPTH-2:0][OUT_W-1:0] fill_q;
    logic [DEPTH-2:0]            flag_q;
    logic                        pend_q;

    logic [OUT_W-1:0]            clamp_data;
    logic                        clamp_flag;
    logic [IN_W-OUT_W:0]         top_bits;

    logic                        slot_free;
    logic                        acc;
    logic                        complete;
    logic                        fire;
    logic                        load;
    logic                        pend_nxt;
    logic [CNT_W-1:0]            n;
    logic [CNT_W-1:0]            shift_el;
    logic [SH_W-1:0]             shamt;
    logic [DEPTH-1:0][OUT_W-1:0] src;
    logic [DEPTH-1:0]            src_flags;
    logic [VEC_W-1:0]            vec_sh;
    logic [DEPTH-1:0]            flag_sh;

    // Clamp the incoming sample; the flag marks any change of value.
    always_comb begin
        clamp_data = in_data[OUT_W-1:0];
        clamp_flag = 1'b0;
        top_bits   = in_data[IN_W-1:OUT_W-1];
        if (SIGNED_OUT == 0) begin
            if (in_data[IN_W-1]) begin
                clamp_data = '0;
                clamp_flag = 1'b1;
            end else if (|in_data[IN_W-1:OUT_W]) begin
                clamp_data = '1;
                clamp_flag = 1'b1;
            end
        end else begin
            // In range iff every bit from OUT_W-1 upward equals the sign.
            if (!(&top_bits) && (|top_bits)) begin
                clamp_flag = 1'b1;
                if (in_data[IN_W-1]) begin
                    clamp_data            = '0;
                    clamp_data[OUT_W-1]   = 1'b1;
                end else begin
                    clamp_data            = '1;
                    clamp_data[OUT_W-1]   = 1'b0;
                end
            end
        end
    end

    // Handshake and event decode.
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = !pend_q && (((level < LAST) && !flush) || slot_free);
        acc       = in_valid && in_ready;
        complete  = acc && (level == LAST);
        n         = level + CNT_W'(acc);
        fire      = (flush || pend_q) && slot_free && (n != '0) && !complete;
        load      = complete || fire;

        pend_nxt = pend_q;
        if (fire) begin
            pend_nxt = 1'b0;
        end else if (flush && !slot_free && (level != '0)) begin
            pend_nxt = 1'b1;
        end
    end

    // Assemble the candidate vector with the newest sample at element 0 and
    // shift it so the oldest real sample lands at element DEPTH-1.
    always_comb begin
        if (acc) begin
            src       = {fill_q, clamp_data};
            src_flags = {flag_q, clamp_flag};
        end else begin
            src       = {OUT_W'(0), fill_q};
            src_flags = {1'b0, flag_q};
        end
        shift_el = CNT_W'(DEPTH) - n;
        shamt    = SH_W'(shift_el) * SH_W'(OUT_W);
        vec_sh   = src << shamt;
        flag_sh  = src_flags << shift_el;
    end

    // Fill register, level and pending-flush state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
            flag_q <= '0;
            level  <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_nxt;
            if (load) begin
                fill_q <= '0;
                flag_q <= '0;
                level  <= '0;
            end else if (acc) begin
                fill_q <= src[DEPTH-2:0];
                flag_q <= src_flags[DEPTH-2:0];
                level  <= level + CNT_W'(1);
            end
        end
    end

    // Output register: a load wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_vector <= '0;
            out_count  <= '0;
            sat_any    <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_vector <= vec_sh;
            out_count  <= n;
            sat_any    <= |flag_sh;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_pack_queue.sv
// Bench for sat_pack_queue: an unsigned-clamp and a signed-clamp instance share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_sat_pack_queue;

    localparam int D  = 16;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic [IW-1:0]   in_data;
    logic            flush;
    logic            out_ready;

    logic            rdy0, rdy1, ov0, ov1, sat0, sat1;
    logic [D*OW-1:0] vec0, vec1;
    logic [CW-1:0]   cnt0, cnt1, lvl0, lvl1;

    always #5 clk = ~clk;

    sat_pack_queue #(.DEPTH(D), .IN_W(IW), .OUT_W(OW), .SIGNED_OUT(0)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .flush(flush), .out_valid(ov0), .out_ready(out_ready),
        .out_vector(vec0), .out_count(cnt0), .sat_any(sat0), .level(lvl0));

    sat_pack_queue #(.DEPTH(D), .IN_W(IW), .OUT_W(OW), .SIGNED_OUT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .flush(flush), .out_valid(ov1), .out_ready(out_ready),
        .out_vector(vec1), .out_count(cnt1), .sat_any(sat1), .level(lvl1));

    int errors = 0;
    int checks = 0;

    // Model state: accepted raw samples, oldest first.
    logic [IW-1:0]   q[$];
    bit              m_valid;
    bit              m_pend;
    logic [D*OW-1:0] m_vec[2];
    logic [CW-1:0]   m_cnt;
    bit              m_sat[2];
    bit              m_acc;
    bit              m_slot;
    logic            last_rdy0;

    logic [IW-1:0] bnd [10] = '{16'h0000, 16'h00FF, 16'h0100, 16'h007F, 16'h0080,
                                16'hFF80, 16'hFF7F, 16'hFFFF, 16'h8000, 16'h7FFF};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void clampm(input logic [IW-1:0] s, input int sg,
                                   output logic [OW-1:0] e, output bit f);
        int v, lo, hi, c;
        v  = int'($signed(s));
        lo = (sg != 0) ? -128 : 0;
        hi = (sg != 0) ? 127 : 255;
        c  = (v < lo) ? lo : ((v > hi) ? hi : v);
        f  = (c != v);
        e  = c[7:0];
    endfunction

    task automatic model_reset();
        q.delete();
        m_valid = 0;
        m_pend  = 0;
        m_cnt   = '0;
        for (int s = 0; s < 2; s++) begin
            m_vec[s] = '0;
            m_sat[s] = 0;
        end
    endtask

    task automatic model_step(input logic f, input logic [IW-1:0] d);
        bit load;
        logic [OW-1:0] e;
        bit fl;
        load = 0;
        if (m_acc) q.push_back(d);
        if (q.size() == D) begin
            load = 1;
        end else if ((f || m_pend) && q.size() > 0) begin
            if (m_slot) begin
                load   = 1;
                m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end
        if (load) begin
            for (int s = 0; s < 2; s++) begin
                m_vec[s] = '0;
                m_sat[s] = 0;
                for (int i = 0; i < q.size(); i++) begin
                    clampm(q[i], s, e, fl);
                    m_vec[s][(D-1-i)*OW +: OW] = e;
                    m_sat[s] = m_sat[s] | fl;
                end
            end
            m_cnt   = CW'(q.size());
            m_valid = 1;
            q.delete();
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare();
        chk("u0_out_valid", ov0, m_valid);
        chk("u1_out_valid", ov1, m_valid);
        chk("u0_level", lvl0, q.size());
        chk("u1_level", lvl1, q.size());
        chk("u0_out_count", cnt0, m_cnt);
        chk("u1_out_count", cnt1, m_cnt);
        chk("u0_out_vector", vec0, m_vec[0]);
        chk("u1_out_vector", vec1, m_vec[1]);
        chk("u0_sat_any", sat0, m_sat[0]);
        chk("u1_sat_any", sat1, m_sat[1]);
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic f, input logic r);
        bit exp_rdy;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        #1;
        m_slot  = !m_valid || r;
        exp_rdy = !m_pend && ((q.size() < D - 1 && !f) || m_slot);
        last_rdy0 = rdy0;
        chk("u0_in_ready", rdy0, exp_rdy);
        chk("u1_in_ready", rdy1, exp_rdy);
        m_acc = v && exp_rdy;
        @(posedge clk);
        model_step(f, d);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [IW-1:0] d;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        compare();
        chk("reset_level", lvl0, 0);
        chk("reset_valid", ov0, 0);

        // Full vector of 1..16.
        for (int i = 0; i < D; i++) cycle(1, IW'(i + 1), 0, 1);
        chk("seq_valid", ov0, 1);
        chk("seq_el15", vec0[127:120], 8'h01);
        chk("seq_el0", vec0[7:0], 8'h10);
        chk("seq_count", cnt0, 16);
        chk("seq_sat", sat0, 0);
        cycle(0, 0, 0, 1);

        // Saturation, both clamp modes.
        cycle(1, 16'h8000, 0, 1);
        cycle(1, 16'h0100, 0, 1);
        cycle(1, 16'h00FF, 0, 1);
        cycle(1, 16'h7FFF, 0, 1);
        for (int i = 0; i < 12; i++) cycle(1, 16'h0005, 0, 1);
        chk("sat_u_top", vec0[127:96], 32'h00FFFFFF);
        chk("sat_s_top", vec1[127:96], 32'h807F7F7F);
        chk("sat_u_el0", vec0[7:0], 8'h05);
        chk("sat_u_any", sat0, 1);
        chk("sat_s_any", sat1, 1);
        cycle(0, 0, 0, 1);

        // Partial flush of 5, then an ignored flush.
        for (int i = 0; i < 5; i++) cycle(1, IW'(i + 1), 0, 1);
        cycle(0, 0, 1, 1);
        chk("flush_count", cnt0, 5);
        chk("flush_top", vec0[127:88], 40'h0102030405);
        chk("flush_low", vec0[87:0], 88'h0);
        chk("flush_level", lvl0, 0);
        cycle(0, 0, 1, 1);
        chk("flush_empty_valid", ov0, 0);

        // Stalled output, fill continues; completing sample waits for the slot.
        for (int i = 0; i < D; i++) cycle(1, IW'(16'h10 + i), 0, 0);
        for (int i = 0; i < D - 1; i++) cycle(1, IW'(16'h20 + i), 0, 0);
        cycle(1, 16'h0030, 0, 0);
        chk("stall_rdy", last_rdy0, 0);
        cycle(1, 16'h0030, 0, 1);
        chk("swap_rdy", last_rdy0, 1);
        chk("swap_valid", ov0, 1);
        chk("swap_el0", vec0[7:0], 8'h30);
        chk("swap_el15", vec0[127:120], 8'h20);
        cycle(0, 0, 0, 1);

        // Flush pending behind a stalled output.
        for (int i = 0; i < D; i++) cycle(1, IW'(16'h50 + i), 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, IW'(16'h41 + i), 0, 0);
        cycle(1, 16'h0044, 1, 0);
        chk("pend_rdy_a", last_rdy0, 0);
        chk("pend_level", lvl0, 3);
        cycle(1, 16'h0044, 0, 0);
        chk("pend_rdy_b", last_rdy0, 0);
        cycle(0, 0, 0, 1);
        chk("pend_count", cnt0, 3);
        chk("pend_valid", ov0, 1);
        chk("pend_top", vec0[127:104], 24'h414243);
        chk("pend_low", vec0[103:0], 104'h0);
        cycle(0, 0, 0, 1);

        // Asynchronous reset with level 9 and a held vector.
        for (int i = 0; i < D; i++) cycle(1, IW'(16'h60 + i), 0, 0);
        for (int i = 0; i < 9; i++) cycle(1, IW'(16'h70 + i), 0, 0);
        chk("prerst_level", lvl0, 9);
        chk("prerst_valid", ov0, 1);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", ov0, 0);
        chk("rst_level", lvl0, 0);
        chk("rst_vector", vec0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_sat", sat1, 0);
        compare();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < D - 1; i++) cycle(1, IW'(i), 0, 1);
        chk("post_rst_15", ov0, 0);
        cycle(1, 16'h00AA, 0, 1);
        chk("post_rst_16", ov0, 1);
        chk("post_rst_count", cnt0, 16);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0:       d = IW'($urandom);
                1:       d = IW'($urandom_range(0, 300));
                2:       d = IW'(int'($urandom_range(0, 600)) - 300);
                default: d = bnd[$urandom_range(0, 9)];
            endcase
            cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
